// File: rtl/sd_read_to_uart.sv
// Reads N SD sectors into a 256x16 buffer and streams each as paced bytes to the UART TX.
// Optional: define SD_READ_CHECKSUM_EN to append an 8-bit sum byte after each sector.
module sd_read_to_uart #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 9600,
  parameter int SECTOR_WORDS = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] sector_cnt,
  input  logic        rd_busy,
  input  logic        rd_data_en,
  input  logic [15:0] rd_data,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  output logic [7:0]  tx_data,
  output logic        tx_flag,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int GAP_CLKS     = (CLK_FREQ / UART_BPS) * 11;
  localparam int PACE_W       = $clog2(GAP_CLKS + 1);
  localparam int WORD_W       = $clog2(SECTOR_WORDS);
  localparam int SECTOR_BYTES = 2 * SECTOR_WORDS;
`ifdef SD_READ_CHECKSUM_EN
  localparam int TOTAL_BYTES  = SECTOR_BYTES + 1;
`else
  localparam int TOTAL_BYTES  = SECTOR_BYTES;
`endif
  localparam int BYTE_W       = $clog2(TOTAL_BYTES + 1);

  localparam logic [WORD_W:0]   WCNT_FULL   = (WORD_W + 1)'(SECTOR_WORDS);
  localparam logic [BYTE_W-1:0] BCNT_END    = BYTE_W'(TOTAL_BYTES);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_BUSY, S_CAPTURE, S_SEND, S_NEXT, S_FIN
  } state_t;

  state_t              state_r, state_next_s;
  logic [15:0]         buf_r [SECTOR_WORDS];
  logic [WORD_W:0]     wcnt_r;
  logic [BYTE_W-1:0]   bcnt_r;
  logic [PACE_W-1:0]   pace_r;
  logic [15:0]         remaining_r;
  logic                rd_en_r, tx_flag_r, busy_r, done_r, err_r;
  logic [31:0]         rd_addr_r;
  logic [7:0]          tx_data_r;
`ifdef SD_READ_CHECKSUM_EN
  logic [7:0]          sum_r;
`endif

  logic                accept_s, rd_en_s, cap_wr_s, short_err_s, fire_s, done_s;
  logic [15:0]         word_s;
  logic [7:0]          byte_s;

  assign rd_en   = rd_en_r;
  assign rd_addr = rd_addr_r;
  assign tx_data = tx_data_r;
  assign tx_flag = tx_flag_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    rd_en_s      = 1'b0;
    cap_wr_s     = 1'b0;
    short_err_s  = 1'b0;
    fire_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (sector_cnt == 16'd0) begin
            done_s       = 1'b1;
            state_next_s = S_IDLE;
          end else begin
            state_next_s = S_REQ;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (!rd_busy) begin
          rd_en_s      = 1'b1;
          state_next_s = S_WAIT_BUSY;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_WAIT_BUSY: begin
        if (rd_busy) begin
          state_next_s = S_CAPTURE;
        end else begin
          state_next_s = S_WAIT_BUSY;
        end
      end
      S_CAPTURE: begin
        cap_wr_s = rd_data_en && (wcnt_r < WCNT_FULL);
        if (!rd_busy) begin
          if (wcnt_r == WCNT_FULL) begin
            state_next_s = S_SEND;
          end else begin
            short_err_s  = 1'b1;
            state_next_s = S_IDLE;
          end
        end else begin
          state_next_s = S_CAPTURE;
        end
      end
      S_SEND: begin
        if (pace_r == {PACE_W{1'b0}}) begin
          if (bcnt_r == BCNT_END) begin
            state_next_s = S_NEXT;
          end else begin
            fire_s       = 1'b1;
            state_next_s = S_SEND;
          end
        end else begin
          state_next_s = S_SEND;
        end
      end
      S_NEXT: begin
        if (remaining_r == 16'd1) begin
          state_next_s = S_FIN;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_FIN: begin
        done_s       = 1'b1;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Byte selection: even index takes the high byte of the buffered word
  always_comb begin
    word_s = buf_r[bcnt_r[WORD_W:1]];
    if (bcnt_r[0]) begin
      byte_s = word_s[7:0];
    end else begin
      byte_s = word_s[15:8];
    end
`ifdef SD_READ_CHECKSUM_EN
    if (bcnt_r == BYTE_W'(SECTOR_BYTES)) begin
      byte_s = sum_r;
    end else begin
      byte_s = byte_s;
    end
`endif
  end

  // Sector buffer write port (contents need no reset)
  always_ff @(posedge sys_clk) begin
    if (cap_wr_s) begin
      buf_r[wcnt_r[WORD_W-1:0]] <= rd_data;
    end
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_en_r     <= 1'b0;
      tx_flag_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_addr_r   <= 32'd0;
      tx_data_r   <= 8'd0;
      remaining_r <= 16'd0;
      wcnt_r      <= '0;
      bcnt_r      <= '0;
      pace_r      <= '0;
`ifdef SD_READ_CHECKSUM_EN
      sum_r       <= 8'd0;
`endif
    end else begin
      rd_en_r   <= rd_en_s;
      tx_flag_r <= fire_s;
      done_r    <= done_s;

      if (accept_s) begin
        rd_addr_r   <= start_addr;
        remaining_r <= sector_cnt;
        err_r       <= 1'b0;
        busy_r      <= (sector_cnt != 16'd0);
      end else if (short_err_s) begin
        err_r  <= 1'b1;
        busy_r <= 1'b0;
      end else if (state_r == S_FIN) begin
        busy_r <= 1'b0;
      end else if (state_r == S_NEXT) begin
        rd_addr_r   <= rd_addr_r + 32'd1;
        remaining_r <= remaining_r - 16'd1;
      end

      if (state_r == S_REQ) begin
        wcnt_r <= '0;
      end else if (cap_wr_s) begin
        wcnt_r <= wcnt_r + (WORD_W + 1)'(1);
      end

      // Pacing restarts on entry to SEND so the first byte goes out one cycle later
      if (state_r == S_CAPTURE) begin
        bcnt_r <= '0;
        pace_r <= '0;
`ifdef SD_READ_CHECKSUM_EN
        sum_r  <= 8'd0;
`endif
      end else if (fire_s) begin
        bcnt_r    <= bcnt_r + BYTE_W'(1);
        pace_r    <= PACE_RELOAD;
        tx_data_r <= byte_s;
`ifdef SD_READ_CHECKSUM_EN
        sum_r     <= sum_r + byte_s;
`endif
      end else if ((state_r == S_SEND) && (pace_r != {PACE_W{1'b0}})) begin
        pace_r <= pace_r - PACE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sd_read_to_uart.sv
// Scoreboard bench for sd_read_to_uart: an SD read model pushes expected bytes, the TX monitor pops and compares.
module tb_sd_read_to_uart;

  localparam int CLK_FREQ = 100;
  localparam int UART_BPS = 100;
  localparam int GAP      = (CLK_FREQ / UART_BPS) * 11;
`ifdef SD_READ_CHECKSUM_EN
  localparam int SEC_BYTES = 513;
`else
  localparam int SEC_BYTES = 512;
`endif
  localparam int BUDGET = 30000;

  logic        sys_clk, sys_rst, start, rd_busy, rd_data_en;
  logic [31:0] start_addr;
  logic [15:0] sector_cnt, rd_data;
  logic        rd_en, tx_flag, busy, done, err;
  logic [31:0] rd_addr;
  logic [7:0]  tx_data;

  sd_read_to_uart #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .SECTOR_WORDS(256)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .start_addr(start_addr),
    .sector_cnt(sector_cnt), .rd_busy(rd_busy), .rd_data_en(rd_data_en), .rd_data(rd_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .tx_data(tx_data), .tx_flag(tx_flag),
    .busy(busy), .done(done), .err(err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int n_words = 256;
  int mode    = 0;
  int tx_cnt = 0, rd_en_cnt = 0, done_cnt = 0, last_tx = 0;
  logic rd_en_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    case (mode)
      0:       return 16'(i + 1);
      1:       return 16'h0101;
      default: return (i == 0) ? 16'h0003 : 16'h0000;
    endcase
  endfunction

  // SD controller read-port model; expected UART bytes are queued as words are returned
  task automatic serve();
    logic [7:0]  sum;
    logic [15:0] w;
    logic [31:0] a;
    sum = 8'h00;
    a = rd_addr;
    if (addr_q.size() == 0) check_eq("rd_addr_unexp", 64'd1, 64'd0);
    else check_eq("rd_addr", 64'(a), 64'(addr_q.pop_front()));
    repeat (2) @(negedge sys_clk);
    rd_busy = 1'b1;
    for (int i = 0; i < n_words; i++) begin
      @(negedge sys_clk);
      w = word_of(i);
      rd_data_en = 1'b1;
      rd_data = w;
      if (n_words == 256) begin
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        sum = sum + w[15:8] + w[7:0];
      end
    end
    @(negedge sys_clk);
    rd_data_en = 1'b0;
    check_eq("rd_addr_hold", 64'(rd_addr), 64'(a));
    rd_busy = 1'b0;
`ifdef SD_READ_CHECKSUM_EN
    if (n_words == 256) exp_q.push_back(sum);
`endif
  endtask

  initial begin
    rd_busy = 1'b0; rd_data_en = 1'b0; rd_data = 16'h0000;
    forever begin
      @(negedge sys_clk);
      if (rd_en === 1'b1) serve();
    end
  end

  // Output monitor: byte scoreboard, strobe spacing, rd_en width, done count
  always @(negedge sys_clk) begin
    if (tx_flag === 1'b1) begin
      tx_cnt++;
      if (exp_q.size() == 0) check_eq("tx_unexp", 64'd1, 64'd0);
      else check_eq("tx_data", 64'(tx_data), 64'(exp_q.pop_front()));
      if (last_tx > 0 && (cyc - last_tx) < 4 * GAP) check_eq("tx_gap", 64'(cyc - last_tx), 64'(GAP));
      last_tx = cyc;
    end
    if (rd_en === 1'b1) begin
      rd_en_cnt++;
      check_eq("rd_en_width", 64'(rd_en_prev), 64'd0);
    end
    rd_en_prev = rd_en;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
    start_addr = a; sector_cnt = n; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt == base && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_tx(input int base, input int n, input string tag);
    int k = 0;
    while (tx_cnt - base < n && k < BUDGET) begin tick(1); k++; end
    if (k >= BUDGET) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic run_one(input logic [31:0] a, input int m, input string tag);
    int tb, db;
    mode = m; n_words = 256;
    tb = tx_cnt; db = done_cnt;
    addr_q.push_back(a);
    pulse_start(a, 16'd1);
    wait_done(db, {tag, "_timeout"});
    check_eq({tag, "_bytes"}, 64'(tx_cnt - tb), 64'(SEC_BYTES));
    check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int tb, rb, db, k;
    sys_rst = 1'b1; start = 1'b0; start_addr = 32'h0; sector_cnt = 16'h0;
    tick(3);
    check_eq("reset_outs", 64'({rd_en, tx_flag, busy, done, err, tx_data, rd_addr}), 64'd0);
    sys_rst = 1'b0;
    tick(2);

    // 1: single sector, incrementing words
    mode = 0; n_words = 256;
    tb = tx_cnt; rb = rd_en_cnt; db = done_cnt;
    addr_q.push_back(32'h10);
    pulse_start(32'h10, 16'd1);
    check_eq("t1_busy", 64'(busy), 64'd1);
    check_eq("t1_err", 64'(err), 64'd0);
    wait_done(db, "t1_timeout");
    check_eq("t1_bytes", 64'(tx_cnt - tb), 64'(SEC_BYTES));
    check_eq("t1_rd_en", 64'(rd_en_cnt - rb), 64'd1);
    check_eq("t1_busy_end", 64'(busy), 64'd0);
    check_eq("t1_addr_end", 64'(rd_addr), 64'h11);
    tick(3);
    check_eq("t1_done_once", 64'(done_cnt - db), 64'd1);

    // 2: three sectors wrapping the address; stray start during SEND
    tb = tx_cnt; rb = rd_en_cnt; db = done_cnt;
    addr_q.push_back(32'hFFFF_FFFE);
    addr_q.push_back(32'hFFFF_FFFF);
    addr_q.push_back(32'h0000_0000);
    pulse_start(32'hFFFF_FFFE, 16'd3);
    wait_tx(tb, 100, "t2_tx_timeout");
    pulse_start(32'h0000_0055, 16'd1);
    wait_done(db, "t2_timeout");
    check_eq("t2_bytes", 64'(tx_cnt - tb), 64'(3 * SEC_BYTES));
    check_eq("t2_rd_en", 64'(rd_en_cnt - rb), 64'd3);
    check_eq("t2_addr_end", 64'(rd_addr), 64'h1);
    tick(2 * GAP);
    check_eq("t2_done_once", 64'(done_cnt - db), 64'd1);
    check_eq("t2_addrq_empty", 64'(addr_q.size()), 64'd0);

    // 3: short sector -> sticky err, then zero-count start clears it
    n_words = 100;
    tb = tx_cnt; rb = rd_en_cnt; db = done_cnt;
    addr_q.push_back(32'h200);
    pulse_start(32'h200, 16'd1);
    k = 0;
    while (err !== 1'b1 && k < 2000) begin tick(1); k++; end
    check_eq("t3_err", 64'(err), 64'd1);
    check_eq("t3_busy", 64'(busy), 64'd0);
    tick(20);
    check_eq("t3_no_tx", 64'(tx_cnt - tb), 64'd0);
    check_eq("t3_no_done", 64'(done_cnt - db), 64'd0);
    check_eq("t3_err_sticky", 64'(err), 64'd1);
    n_words = 256;
    rb = rd_en_cnt;
    pulse_start(32'h300, 16'd0);
    check_eq("t3_err_clr", 64'(err), 64'd0);
    check_eq("t5_zero_done", 64'(done), 64'd1);
    check_eq("t5_zero_busy", 64'(busy), 64'd0);
    tick(5);
    check_eq("t5_zero_no_rd", 64'(rd_en_cnt - rb), 64'd0);

    // 5: reset in the middle of SEND
    mode = 0;
    tb = tx_cnt; db = done_cnt;
    addr_q.push_back(32'h40);
    pulse_start(32'h40, 16'd1);
    wait_tx(tb, 200, "t5_tx_timeout");
    sys_rst = 1'b1;
    tick(1);
    check_eq("t5_rst_outs", 64'({rd_en, tx_flag, busy, done, err, tx_data, rd_addr}), 64'd0);
    sys_rst = 1'b0;
    tb = tx_cnt; rb = rd_en_cnt;
    tick(3 * GAP);
    check_eq("t5_no_tx", 64'(tx_cnt - tb), 64'd0);
    check_eq("t5_no_rd", 64'(rd_en_cnt - rb), 64'd0);
    check_eq("t5_no_done", 64'(done_cnt - db), 64'd0);
    exp_q.delete();

    // 6: data patterns relevant to the checksum byte
    run_one(32'h500, 1, "t6a");
    run_one(32'h600, 2, "t6b");

    tick(5);
    check_eq("end_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
